// File: rtl/dft_scan_pkg.sv
// dft_scan_pkg: shared definitions for the scan-chain responder.
//   - state_t       : responder FSM encoding (IDLE=0, ACK=1, SHIFT=2, COMMIT=3)
//   - WORD_W        : output word width (32)
//   - word_count()  : number of WORD_W words needed to hold a bit count
//   - SIG_*         : field offsets of the optional signature word
package dft_scan_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Signature word layout: [15:0] chain length, [16] chain parity, rest 0.
    localparam int SIG_LEN_LSB    = 0;
    localparam int SIG_LEN_W      = 16;
    localparam int SIG_PARITY_BIT = 16;

    function automatic int word_count(input int bits);
        return (bits + WORD_W - 1) / WORD_W;
    endfunction

endpackage

// File: rtl/dft_word_packer.sv
// dft_word_packer: serial-in, LSB-first packer producing WORD_W-bit words.
// Each accepted bit lands at the current bit position. When the word fills,
// or the caller flags the final chain bit, the word is moved to the output
// register and word_done pulses for one cycle. The accumulator restarts from
// zero, so unused high bits of a short final word come out as 0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart packing at bit 0 (start of an unload)
//   shift      : accept bit_in this cycle
//   bit_in     : serial data bit
//   last       : bit_in is the final chain bit (flush a partial word)
//   word       : most recently completed word (held)
//   word_done  : one-cycle pulse, word just updated
module dft_word_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic              bit_in,
    input  logic              last,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    localparam int PW = $clog2(WORD_W);

    logic [WORD_W-1:0] acc;
    logic [PW-1:0]     pos;
    logic [WORD_W-1:0] merged;

    // Accumulator with the incoming bit already inserted.
    always_comb begin
        merged      = acc;
        merged[pos] = bit_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            pos       <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            pos       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (shift) begin
                if (pos == PW'(WORD_W - 1) || last) begin
                    word      <= merged;
                    word_done <= 1'b1;
                    acc       <= '0;
                    pos       <= '0;
                end else begin
                    acc <= merged;
                    pos <= pos + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/simple_counter.sv
// simple_counter: up-counter library cell with synchronous clear.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous clear (priority over en)
//   en         : count enable
//   count      : current count
module simple_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (en)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/dft_scan_responder.sv
// dft_scan_responder: chain-side responder for the DFT
// val_op/op_ack/op_commit/commit_ack handshake, one per scan chain.
// On a request it rotates the whole chain once (scan_in fed from scan_out,
// so the chain ends up unchanged), packs the bits LSB-first into 32-bit
// words, strobes each word out, then raises op_commit until acknowledged.
// Optional build macro: DFT_SCAN_SIGNATURE_EN appends a signature word
// (chain length + chain parity) after the data words.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   dft_val_op         : scan request (level)
//   dft_op_ack         : request accepted, held while dft_val_op stays high
//   dft_op_commit      : unload complete, held until dft_commit_ack
//   dft_commit_ack     : controller commit acknowledge (level)
//   dft_output_strobe  : one-cycle pulse, dft_output_data valid
//   dft_output_data    : packed chain word, held between strobes
//   scan_en            : chain shift enable
//   scan_in            : serial input to chain head
//   scan_out           : serial output from chain tail
module dft_scan_responder
    import dft_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dft_val_op,
    output logic              dft_op_ack,
    output logic              dft_op_commit,
    input  logic              dft_commit_ack,
    output logic              dft_output_strobe,
    output logic [WORD_W-1:0] dft_output_data,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out
);

    localparam int NW = word_count(CHAIN_LEN);
`ifdef DFT_SCAN_SIGNATURE_EN
    localparam int NW_EFF = NW + 1;
`else
    localparam int NW_EFF = NW;
`endif
    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int WCW = $clog2(NW_EFF + 1);

    state_t            state;
    logic [BCW-1:0]    bit_cnt;
    logic [WCW-1:0]    word_cnt;
    logic              shift_start;
    logic              last_bit;
    logic              word_done;
    logic [WORD_W-1:0] packed_word;

    // ACK -> SHIFT transition: restart counters and packer.
    assign shift_start = (state == ST_ACK) && !dft_val_op;
    assign last_bit    = (bit_cnt == BCW'(CHAIN_LEN - 1));

    // Recirculate so the chain is restored after CHAIN_LEN shifts.
    assign scan_in = scan_en ? scan_out : 1'b0;

    simple_counter #(.WIDTH(BCW)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (shift_start),
        .en    (scan_en),
        .count (bit_cnt)
    );

    // word_cnt equals the index of the word being strobed in a strobe cycle.
    simple_counter #(.WIDTH(WCW)) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (shift_start),
        .en    (dft_output_strobe),
        .count (word_cnt)
    );

    dft_word_packer #(.WORD_W(WORD_W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (shift_start),
        .shift     (scan_en),
        .bit_in    (scan_out),
        .last      (last_bit),
        .word      (packed_word),
        .word_done (word_done)
    );

`ifdef DFT_SCAN_SIGNATURE_EN
    logic              parity;
    logic [WORD_W-1:0] sig_word;

    always_ff @(posedge clk) begin
        if (reset || shift_start)
            parity <= 1'b0;
        else if (scan_en)
            parity <= parity ^ scan_out;
    end

    always_comb begin
        sig_word = '0;
        sig_word[SIG_LEN_LSB +: SIG_LEN_W] = SIG_LEN_W'(CHAIN_LEN);
        sig_word[SIG_PARITY_BIT]           = parity;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            dft_op_ack        <= 1'b0;
            dft_op_commit     <= 1'b0;
            scan_en           <= 1'b0;
            dft_output_strobe <= 1'b0;
            dft_output_data   <= '0;
        end else begin
            dft_output_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A request seen while the previous ack is still up waits.
                    if (dft_val_op && !dft_commit_ack) begin
                        state      <= ST_ACK;
                        dft_op_ack <= 1'b1;
                    end
                end
                ST_ACK: begin
                    // Ack stays visible until the controller drops val_op.
                    if (!dft_val_op) begin
                        state      <= ST_SHIFT;
                        dft_op_ack <= 1'b0;
                        scan_en    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (scan_en && last_bit)
                        scan_en <= 1'b0;
                    if (word_done) begin
                        dft_output_strobe <= 1'b1;
                        dft_output_data   <= packed_word;
                    end
`ifdef DFT_SCAN_SIGNATURE_EN
                    // Signature follows the last data strobe directly.
                    else if (dft_output_strobe && word_cnt == WCW'(NW - 1)) begin
                        dft_output_strobe <= 1'b1;
                        dft_output_data   <= sig_word;
                    end
`endif
                    if (dft_output_strobe && word_cnt == WCW'(NW_EFF - 1)) begin
                        state         <= ST_COMMIT;
                        dft_op_commit <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (dft_commit_ack) begin
                        state         <= ST_IDLE;
                        dft_op_commit <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_scan_responder.sv
// tb_dft_scan_responder: bench for dft_scan_responder. Two instances
// (CHAIN_LEN 40 and 64) each drive a behavioural scan chain. A schedule
// model predicts every output per cycle from the unload timeline; directed
// tests add hand-computed literal checks. Honours DFT_SCAN_SIGNATURE_EN.
module tb_dft_scan_responder;

    localparam int L0 = 40;
    localparam int L1 = 64;
`ifdef DFT_SCAN_SIGNATURE_EN
    localparam int SIGW = 1;
`else
    localparam int SIGW = 0;
`endif

    logic        clk = 1'b0;
    logic        rst [2];
    logic        val_op [2];
    logic        cack [2];
    logic        ack [2];
    logic        commit [2];
    logic        strobe [2];
    logic [31:0] data [2];
    logic        se [2];
    logic        sin [2];
    logic        sout [2];

    logic [L0-1:0] ch0 = '0;
    logic [L1-1:0] ch1 = '0;
    logic [L0-1:0] ldv0 = '0;
    logic [L1-1:0] ldv1 = '0;
    logic          ld [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic mon_on = 1'b0;

    // model state: phase 0 idle, 1 ack, 2 shift (t = cycles since entry), 3 commit
    int          m_ph [2] = '{0, 0};
    int          m_t [2]  = '{0, 0};
    logic [31:0] m_data [2] = '{32'h0, 32'h0};
    logic [63:0] g [2] = '{64'h0, 64'h0};

    logic [31:0] wq0 [$];
    logic [31:0] wq1 [$];
    int          rq1 [$];
    int          s_entry1 = 0;
    logic        prev_se1 = 1'b0;

    always #5 clk = ~clk;

    dft_scan_responder #(.CHAIN_LEN(L0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .dft_val_op(val_op[0]), .dft_op_ack(ack[0]),
        .dft_op_commit(commit[0]), .dft_commit_ack(cack[0]),
        .dft_output_strobe(strobe[0]), .dft_output_data(data[0]),
        .scan_en(se[0]), .scan_in(sin[0]), .scan_out(sout[0]));

    dft_scan_responder #(.CHAIN_LEN(L1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .dft_val_op(val_op[1]), .dft_op_ack(ack[1]),
        .dft_op_commit(commit[1]), .dft_commit_ack(cack[1]),
        .dft_output_strobe(strobe[1]), .dft_output_data(data[1]),
        .scan_en(se[1]), .scan_in(sin[1]), .scan_out(sout[1]));

    // behavioural scan chains, tail at bit 0
    assign sout[0] = ch0[0];
    assign sout[1] = ch1[0];
    always @(posedge clk) begin
        if (ld[0]) ch0 <= ldv0;
        else if (se[0]) ch0 <= {sin[0], ch0[L0-1:1]};
        if (ld[1]) ch1 <= ldv1;
        else if (se[1]) ch1 <= {sin[1], ch1[L1-1:1]};
        cyc <= cyc + 1;
    end

    function automatic int len_of(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int nw_of(input int i);
        return (len_of(i) + 31) / 32;
    endfunction

    // word index strobed at shift-relative cycle t, or -1
    function automatic int strobe_idx(input int i, input int t);
        int l;
        l = len_of(i);
        for (int w = 0; w < nw_of(i); w++)
            if (t == (((32 * (w + 1)) < l) ? 32 * (w + 1) : l) + 1) return w;
        if (SIGW == 1 && t == l + 2) return nw_of(i);
        return -1;
    endfunction

    function automatic logic [31:0] word_of(input int i, input int w);
        logic [63:0] v;
        v = g[i];
        if (w >= nw_of(i)) return {15'b0, ^v, 16'(len_of(i))};
        return 32'(v >> (32 * w));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_ph[i] <= 0; m_t[i] <= 0; m_data[i] <= 32'h0;
            end else begin
                case (m_ph[i])
                    0: if (val_op[i] && !cack[i]) m_ph[i] <= 1;
                    1: if (!val_op[i]) begin m_ph[i] <= 2; m_t[i] <= 0; end
                    2: begin
                        if (m_t[i] == len_of(i) + 1 + SIGW) m_ph[i] <= 3;
                        m_t[i] <= m_t[i] + 1;
                        if (strobe_idx(i, m_t[i] + 1) >= 0)
                            m_data[i] <= word_of(i, strobe_idx(i, m_t[i] + 1));
                    end
                    default: if (cack[i]) m_ph[i] <= 0;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("op_ack", i, 32'(ack[i]), 32'(m_ph[i] == 1));
                chk("op_commit", i, 32'(commit[i]), 32'(m_ph[i] == 3));
                chk("scan_en", i, 32'(se[i]), 32'(m_ph[i] == 2 && m_t[i] < len_of(i)));
                chk("scan_in", i, 32'(sin[i]), 32'((m_ph[i] == 2 && m_t[i] < len_of(i)) ? sout[i] : 1'b0));
                chk("strobe", i, 32'(strobe[i]), 32'(m_ph[i] == 2 && strobe_idx(i, m_t[i]) >= 0));
                chk("data", i, data[i], m_data[i]);
            end
            if (strobe[0]) wq0.push_back(data[0]);
            if (strobe[1]) begin
                wq1.push_back(data[1]);
                rq1.push_back(cyc - s_entry1);
            end
            if (se[1] && !prev_se1) s_entry1 <= cyc;
            prev_se1 <= se[1];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [63:0] v);
        if (i == 0) begin ldv0 = v[L0-1:0]; g[0] = {24'b0, v[L0-1:0]}; end
        else begin ldv1 = v; g[1] = v; end
        ld[i] = 1'b1;
        tick(1);
        ld[i] = 1'b0;
    endtask

    task automatic wait_commit(input int i);
        int k;
        k = 0;
        while (!commit[i] && k < 400) begin tick(1); k++; end
        chk("commit_seen", i, 32'(commit[i]), 32'd1);
    endtask

    task automatic wait_se(input int i);
        int k;
        k = 0;
        while (!se[i] && k < 20) begin tick(1); k++; end
        chk("shift_seen", i, 32'(se[i]), 32'd1);
    endtask

    task automatic finish_commit(input int i);
        cack[i] = 1'b1;
        tick(1);
        cack[i] = 1'b0;
    endtask

    task automatic unload(input int i);
        val_op[i] = 1'b1;
        tick(1);
        val_op[i] = 1'b0;
        wait_commit(i);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; val_op[i] = 1'b0; cack[i] = 1'b0; ld[i] = 1'b0;
        end
        tick(2);
        mon_on = 1'b1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick(1);
        // reset state
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", i, 32'(ack[i]), 32'd0);
            chk("rst_commit", i, 32'(commit[i]), 32'd0);
            chk("rst_strobe", i, 32'(strobe[i]), 32'd0);
            chk("rst_data", i, data[i], 32'd0);
            chk("rst_scan_en", i, 32'(se[i]), 32'd0);
        end

        // 1: val_op held 3 cycles, ack for 3 cycles, two words, chain restored
        load(0, 64'hA5_1234_5678);
        wq0.delete();
        n = 0;
        val_op[0] = 1'b1; n += int'(ack[0]);
        tick(1); n += int'(ack[0]);
        tick(1); n += int'(ack[0]);
        tick(1); val_op[0] = 1'b0; n += int'(ack[0]);
        tick(1); n += int'(ack[0]);
        chk("ack_cycles", 0, 32'(n), 32'd3);
        wait_commit(0);
        chk("t1_nwords", 0, 32'(wq0.size()), 32'(2 + SIGW));
        chk("t1_word0", 0, wq0[0], 32'h12345678);
        chk("t1_word1", 0, wq0[1], 32'h000000A5);
        chk("t1_chain", 0, ch0[31:0], 32'h12345678);
        chk("t1_chain_hi", 0, 32'(ch0[39:32]), 32'hA5);

        // 2: commit held while ack low, IDLE after ack, identical second unload
        n = 0;
        for (int k = 0; k < 10; k++) begin n += int'(commit[0]); tick(1); end
        chk("commit_hold", 0, 32'(n), 32'd10);
        cack[0] = 1'b1;
        tick(1);
        chk("commit_drop", 0, 32'(commit[0]), 32'd0);
        cack[0] = 1'b0;
        wq0.delete();
        unload(0);
        chk("t2_word0", 0, wq0[0], 32'h12345678);
        chk("t2_word1", 0, wq0[1], 32'h000000A5);
        finish_commit(0);

        // 5: val_op with commit_ack still high waits
        val_op[0] = 1'b1; cack[0] = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin tick(1); n += int'(ack[0]); end
        chk("t5_no_ack", 0, 32'(n), 32'd0);
        cack[0] = 1'b0;
        tick(1);
        chk("t5_ack", 0, 32'(ack[0]), 32'd1);
        val_op[0] = 1'b0;
        wait_commit(0);
        finish_commit(0);

        // 6: seven ones -> parity 1; signature word when enabled
        load(0, 64'h7F);
        wq0.delete();
        unload(0);
        chk("t6_nwords", 0, 32'(wq0.size()), 32'(2 + SIGW));
        chk("t6_word0", 0, wq0[0], 32'h0000007F);
        chk("t6_word1", 0, wq0[1], 32'h00000000);
`ifdef DFT_SCAN_SIGNATURE_EN
        chk("t6_sig", 0, wq0[2], 32'h00010028);
`endif
        finish_commit(0);

        // 3: 64 ones, strobes at 33/65, val_op/commit_ack ignored mid-shift
        load(1, {64{1'b1}});
        wq1.delete(); rq1.delete();
        val_op[1] = 1'b1;
        tick(1);
        val_op[1] = 1'b0;
        wait_se(1);
        tick(5);
        val_op[1] = 1'b1; cack[1] = 1'b1;
        tick(2);
        val_op[1] = 1'b0; cack[1] = 1'b0;
        wait_commit(1);
        chk("t3_nwords", 1, 32'(wq1.size()), 32'(2 + SIGW));
        chk("t3_word0", 1, wq1[0], 32'hFFFFFFFF);
        chk("t3_word1", 1, wq1[1], 32'hFFFFFFFF);
        chk("t3_rel0", 1, 32'(rq1[0]), 32'd33);
        chk("t3_rel1", 1, 32'(rq1[1]), 32'd65);
        finish_commit(1);

        // 4: reset at shift cycle 17, then a fresh unload
        load(1, 64'h0123_4567_89AB_CDEF);
        val_op[1] = 1'b1;
        tick(1);
        val_op[1] = 1'b0;
        wait_se(1);
        tick(17);
        rst[1] = 1'b1;
        tick(1);
        chk("t4_scan_en", 1, 32'(se[1]), 32'd0);
        chk("t4_strobe", 1, 32'(strobe[1]), 32'd0);
        chk("t4_ack", 1, 32'(ack[1]), 32'd0);
        chk("t4_commit", 1, 32'(commit[1]), 32'd0);
        chk("t4_data", 1, data[1], 32'd0);
        rst[1] = 1'b0;
        load(1, 64'h0123_4567_89AB_CDEF);
        wq1.delete(); rq1.delete();
        unload(1);
        chk("t4_rel0", 1, 32'(rq1[0]), 32'd33);
        chk("t4_word0", 1, wq1[0], 32'h89ABCDEF);
        chk("t4_word1", 1, wq1[1], 32'h01234567);
        chk("t4_chain", 1, ch1[31:0], 32'h89ABCDEF);
        finish_commit(1);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
